// File: rtl/phase_sequencer.sv
// Phase sequencer for the multi-cycle RISC-V core: one-hot FETCH..WB phase FSM
// with halt / single-step / resume debug control and a retired-instruction counter.
module phase_sequencer #(
  parameter int RETW          = 32,
  parameter bit HALT_ON_RESET = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_fetch,
  input  logic            stall_decode,
  input  logic            stall_execute,
  input  logic            stall_memoryaccess,
  input  logic            stall_writeback,
  input  logic            halt_req,
  input  logic            step_req,
  input  logic            resume_req,
  output logic            phase_fetch,
  output logic            phase_decode,
  output logic            phase_execute,
  output logic            phase_memoryaccess,
  output logic            phase_writeback,
  output logic            halted,
  output logic            retire_pulse,
  output logic [RETW-1:0] retire_count
);

  localparam int NS       = 7;
  localparam int S_RESET  = 0;
  localparam int S_FETCH  = 1;
  localparam int S_DECODE = 2;
  localparam int S_EXEC   = 3;
  localparam int S_MEMACC = 4;
  localparam int S_WB     = 5;
  localparam int S_HALT   = 6;
  localparam int NPHASE   = 5;

  localparam logic [NS-1:0] ST_RESET  = 7'b000_0001;
  localparam logic [NS-1:0] ST_FETCH  = 7'b000_0010;
  localparam logic [NS-1:0] ST_DECODE = 7'b000_0100;
  localparam logic [NS-1:0] ST_EXEC   = 7'b000_1000;
  localparam logic [NS-1:0] ST_MEMACC = 7'b001_0000;
  localparam logic [NS-1:0] ST_WB     = 7'b010_0000;
  localparam logic [NS-1:0] ST_HALT   = 7'b100_0000;

  logic [NS-1:0]     state_reg,        state_next;
  logic              halt_pend_reg,    halt_pend_next;
  logic              step_mode_reg,    step_mode_next;
  logic [RETW-1:0]   retire_count_reg, retire_count_next;
  logic              wb_done;
  logic              enter_halt;
  logic [NPHASE-1:0] phase_vec;

  assign wb_done    = state_reg[S_WB] & ~stall_writeback;
  assign enter_halt = state_next[S_HALT] & ~state_reg[S_HALT];

  // State register and debug flags; rst abandons any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= ST_RESET;
      halt_pend_reg    <= 1'b0;
      step_mode_reg    <= 1'b0;
      retire_count_reg <= '0;
    end else begin
      state_reg        <= state_next;
      halt_pend_reg    <= halt_pend_next;
      step_mode_reg    <= step_mode_next;
      retire_count_reg <= retire_count_next;
    end
  end

  // Next-state logic; any non-one-hot value falls back to RESET.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RESET:  state_next = HALT_ON_RESET ? ST_HALT : ST_FETCH;
      ST_FETCH:  if (!stall_fetch)        state_next = ST_DECODE;
      ST_DECODE: if (!stall_decode)       state_next = ST_EXEC;
      ST_EXEC:   if (!stall_execute)      state_next = ST_MEMACC;
      ST_MEMACC: if (!stall_memoryaccess) state_next = ST_WB;
      ST_WB: begin
        if (!stall_writeback) begin
          state_next = (halt_pend_reg || halt_req || step_mode_reg) ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT:   if (resume_req || step_req) state_next = ST_FETCH;
      default:   state_next = ST_RESET;
    endcase
  end

  // Flag and counter updates. step_mode is only ever nonzero between a step
  // request and the WB of that one instruction, so clearing it on any WB is safe.
  always_comb begin
    halt_pend_next    = halt_pend_reg;
    step_mode_next    = step_mode_reg;
    retire_count_next = retire_count_reg;

    if (enter_halt) begin
      halt_pend_next = 1'b0;
    end else if (halt_req && !state_reg[S_HALT]) begin
      halt_pend_next = 1'b1;
    end

    if (state_reg[S_HALT]) begin
      step_mode_next = step_req & ~resume_req;
    end else if (wb_done) begin
      step_mode_next = 1'b0;
    end

    if (wb_done) begin
      retire_count_next = retire_count_reg + RETW'(1);
    end
  end

  for (genvar gi = 0; gi < NPHASE; gi++) begin : g_phase
    assign phase_vec[gi] = state_reg[S_FETCH + gi];
  end

  // Phase and halted outputs come straight from flops; only retire_pulse sees an input.
  always_comb begin
    phase_fetch        = phase_vec[0];
    phase_decode       = phase_vec[1];
    phase_execute      = phase_vec[2];
    phase_memoryaccess = phase_vec[3];
    phase_writeback    = phase_vec[4];
    halted             = state_reg[S_HALT];
    retire_pulse       = wb_done;
  end

  assign retire_count = retire_count_reg;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: phase order, stalls, halt/step/resume,
// counter wrap (RETW=4) and asynchronous reset mid-instruction.
module tb_phase_sequencer;

  localparam logic [2:0] C_RST = 3'd0;
  localparam logic [2:0] C_F   = 3'd1;
  localparam logic [2:0] C_D   = 3'd2;
  localparam logic [2:0] C_E   = 3'd3;
  localparam logic [2:0] C_M   = 3'd4;
  localparam logic [2:0] C_W   = 3'd5;
  localparam logic [2:0] C_H   = 3'd6;
  localparam logic [2:0] C_BAD = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_fetch = 1'b0, stall_decode = 1'b0, stall_execute = 1'b0;
  logic stall_memoryaccess = 1'b0, stall_writeback = 1'b0;
  logic halt_req = 1'b0, step_req = 1'b0, resume_req = 1'b0;

  logic phase_fetch, phase_decode, phase_execute, phase_memoryaccess, phase_writeback;
  logic halted, retire_pulse;
  logic [3:0] retire_count;

  logic h_fetch, h_decode, h_execute, h_memacc, h_wb, h_halted, h_pulse;
  logic [31:0] h_count;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_count = 4'd0;

  always #5 clk = ~clk;

  phase_sequencer #(.RETW(4), .HALT_ON_RESET(1'b0)) u_dut (
    .clk(clk), .rst(rst),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_execute(stall_execute),
    .stall_memoryaccess(stall_memoryaccess), .stall_writeback(stall_writeback),
    .halt_req(halt_req), .step_req(step_req), .resume_req(resume_req),
    .phase_fetch(phase_fetch), .phase_decode(phase_decode), .phase_execute(phase_execute),
    .phase_memoryaccess(phase_memoryaccess), .phase_writeback(phase_writeback),
    .halted(halted), .retire_pulse(retire_pulse), .retire_count(retire_count)
  );

  phase_sequencer #(.RETW(32), .HALT_ON_RESET(1'b1)) u_dut_h (
    .clk(clk), .rst(rst),
    .stall_fetch(stall_fetch), .stall_decode(stall_decode), .stall_execute(stall_execute),
    .stall_memoryaccess(stall_memoryaccess), .stall_writeback(stall_writeback),
    .halt_req(halt_req), .step_req(step_req), .resume_req(resume_req),
    .phase_fetch(h_fetch), .phase_decode(h_decode), .phase_execute(h_execute),
    .phase_memoryaccess(h_memacc), .phase_writeback(h_wb),
    .halted(h_halted), .retire_pulse(h_pulse), .retire_count(h_count)
  );

  // v = {halt, step, resume, stall_f, stall_d, stall_e, stall_m, stall_w}
  task automatic drive(input logic [7:0] v);
    {halt_req, step_req, resume_req, stall_fetch, stall_decode,
     stall_execute, stall_memoryaccess, stall_writeback} = v;
  endtask

  function automatic logic [2:0] phase_code();
    case ({halted, phase_writeback, phase_memoryaccess, phase_execute, phase_decode, phase_fetch})
      6'b000000: return C_RST;
      6'b000001: return C_F;
      6'b000010: return C_D;
      6'b000100: return C_E;
      6'b001000: return C_M;
      6'b010000: return C_W;
      6'b100000: return C_H;
      default:   return C_BAD;
    endcase
  endfunction

  task automatic test_reset();
    drive(8'h00);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (phase_code() !== C_RST) begin bad++; $display("FAIL reset_state: got %0d want %0d", phase_code(), C_RST); end
    total++;
    if (retire_pulse !== 1'b0 || retire_count !== 4'd0) begin
      bad++; $display("FAIL reset_retire: pulse=%0b count=%0d want 0/0", retire_pulse, retire_count);
    end
    total++;
    if (h_halted !== 1'b0) begin bad++; $display("FAIL reset_h_halted: got %0b want 0", h_halted); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (phase_code() !== C_RST) begin bad++; $display("FAIL release_still_reset: got %0d want %0d", phase_code(), C_RST); end
    @(posedge clk); #1;
    total++;
    if (phase_code() !== C_F) begin bad++; $display("FAIL release_fetch: got %0d want %0d", phase_code(), C_F); end
    total++;
    if (h_halted !== 1'b1 || {h_fetch, h_decode, h_execute, h_memacc, h_wb, h_pulse} !== 6'b0 || h_count !== 32'd0) begin
      bad++; $display("FAIL halt_on_reset: halted=%0b phases=%06b count=%0d want 1/000000/0",
                      h_halted, {h_fetch, h_decode, h_execute, h_memacc, h_wb, h_pulse}, h_count);
    end
    $display("reset released");
  endtask

  task automatic test_free_run(input int n_instr, input string name);
    logic [2:0] want;
    logic       exp_pulse;
    for (int i = 0; i < n_instr * 5; i++) begin
      drive(8'h00);
      @(negedge clk);
      want = C_F + 3'(i % 5);
      exp_pulse = (want == C_W);
      total++;
      if (phase_code() !== want) begin bad++; $display("FAIL %s_phase cyc%0d: got %0d want %0d", name, i, phase_code(), want); end
      total++;
      if (retire_pulse !== exp_pulse) begin bad++; $display("FAIL %s_pulse cyc%0d: got %0b want %0b", name, i, retire_pulse, exp_pulse); end
      total++;
      if (retire_count !== exp_count) begin bad++; $display("FAIL %s_count cyc%0d: got %0d want %0d", name, i, retire_count, exp_count); end
      if (exp_pulse) begin
        exp_count = exp_count + 4'd1;
        $display("%s retire count->%0d", name, exp_count);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_execute();
    logic [7:0] vec [9];
    logic [2:0] want [9];
    logic       exp_pulse;
    vec  = '{8'h00, 8'h00, 8'h0C, 8'h04, 8'h0C, 8'h04, 8'h08, 8'h00, 8'h00};
    want = '{C_F, C_D, C_E, C_E, C_E, C_E, C_E, C_M, C_W};
    for (int i = 0; i < 9; i++) begin
      drive(vec[i]);
      @(negedge clk);
      exp_pulse = (want[i] == C_W) && !vec[i][0];
      total++;
      if (phase_code() !== want[i]) begin bad++; $display("FAIL stall_ex_phase cyc%0d: got %0d want %0d", i, phase_code(), want[i]); end
      total++;
      if (retire_pulse !== exp_pulse) begin bad++; $display("FAIL stall_ex_pulse cyc%0d: got %0b want %0b", i, retire_pulse, exp_pulse); end
      total++;
      if (retire_count !== exp_count) begin bad++; $display("FAIL stall_ex_count cyc%0d: got %0d want %0d", i, retire_count, exp_count); end
      if (exp_pulse) begin exp_count = exp_count + 4'd1; $display("stall_execute retire count->%0d", exp_count); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall_other();
    logic [7:0] vec [8];
    logic [2:0] want [8];
    logic       exp_pulse;
    // fetch stall, foreign stalls ignored in E/M, writeback held two cycles
    vec  = '{8'h10, 8'h00, 8'h00, 8'h02, 8'h01, 8'h01, 8'h11, 8'h00};
    want = '{C_F, C_F, C_D, C_E, C_M, C_W, C_W, C_W};
    for (int i = 0; i < 8; i++) begin
      drive(vec[i]);
      @(negedge clk);
      exp_pulse = (want[i] == C_W) && !vec[i][0];
      total++;
      if (phase_code() !== want[i]) begin bad++; $display("FAIL stall_other_phase cyc%0d: got %0d want %0d", i, phase_code(), want[i]); end
      total++;
      if (retire_pulse !== exp_pulse) begin bad++; $display("FAIL stall_other_pulse cyc%0d: got %0b want %0b", i, retire_pulse, exp_pulse); end
      total++;
      if (retire_count !== exp_count) begin bad++; $display("FAIL stall_other_count cyc%0d: got %0d want %0d", i, retire_count, exp_count); end
      if (exp_pulse) begin exp_count = exp_count + 4'd1; $display("stall_other retire count->%0d", exp_count); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_halt();
    logic [7:0] vec [7];
    logic [2:0] want [7];
    logic       exp_pulse;
    // halt pulse in DECODE; a second halt_req while halted must not set halt_pend
    vec  = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
    want = '{C_F, C_D, C_E, C_M, C_W, C_H, C_H};
    for (int i = 0; i < 7; i++) begin
      drive(vec[i]);
      @(negedge clk);
      exp_pulse = (want[i] == C_W) && !vec[i][0];
      total++;
      if (phase_code() !== want[i]) begin bad++; $display("FAIL halt_phase cyc%0d: got %0d want %0d", i, phase_code(), want[i]); end
      total++;
      if (retire_pulse !== exp_pulse) begin bad++; $display("FAIL halt_pulse cyc%0d: got %0b want %0b", i, retire_pulse, exp_pulse); end
      total++;
      if (retire_count !== exp_count) begin bad++; $display("FAIL halt_count cyc%0d: got %0d want %0d", i, retire_count, exp_count); end
      if (exp_pulse) begin exp_count = exp_count + 4'd1; $display("halt retire count->%0d", exp_count); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_step_resume();
    logic [7:0] vec [18];
    logic [2:0] want [18];
    logic       exp_pulse;
    // step (with a redundant halt in EXECUTE), then step+resume -> free run;
    // resume_req outside HALT is ignored
    vec  = '{8'h40, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h60, 8'h00,
             8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
    want = '{C_H, C_F, C_D, C_E, C_M, C_W, C_H, C_H, C_F,
             C_D, C_E, C_M, C_W, C_F, C_D, C_E, C_M, C_W};
    for (int i = 0; i < 18; i++) begin
      drive(vec[i]);
      @(negedge clk);
      exp_pulse = (want[i] == C_W) && !vec[i][0];
      total++;
      if (phase_code() !== want[i]) begin bad++; $display("FAIL step_phase cyc%0d: got %0d want %0d", i, phase_code(), want[i]); end
      total++;
      if (retire_pulse !== exp_pulse) begin bad++; $display("FAIL step_pulse cyc%0d: got %0b want %0b", i, retire_pulse, exp_pulse); end
      total++;
      if (retire_count !== exp_count) begin bad++; $display("FAIL step_count cyc%0d: got %0d want %0d", i, retire_count, exp_count); end
      if (exp_pulse) begin exp_count = exp_count + 4'd1; $display("step_resume retire count->%0d", exp_count); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    drive(8'h00);
    @(negedge clk);
    total++;
    if (phase_code() !== C_F || retire_count !== 4'd1) begin
      bad++; $display("FAIL wrap_final: phase=%0d count=%0d want %0d/1", phase_code(), retire_count, C_F);
    end
    repeat (3) begin @(posedge clk); #1; end
    drive(8'h02);
    @(negedge clk);
    total++;
    if (phase_code() !== C_M) begin bad++; $display("FAIL rstmid_memacc: got %0d want %0d", phase_code(), C_M); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    total++;
    if (phase_code() !== C_RST || retire_pulse !== 1'b0 || retire_count !== 4'd0) begin
      bad++; $display("FAIL rstmid_async: phase=%0d pulse=%0b count=%0d want 0/0/0", phase_code(), retire_pulse, retire_count);
    end
    exp_count = 4'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    drive(8'h00);
    @(negedge clk);
    total++;
    if (phase_code() !== C_RST) begin bad++; $display("FAIL rstmid_release: got %0d want %0d", phase_code(), C_RST); end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (phase_code() !== C_F || retire_count !== 4'd0) begin
      bad++; $display("FAIL rstmid_fetch: phase=%0d count=%0d want %0d/0", phase_code(), retire_count, C_F);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (phase_code() !== C_D) begin bad++; $display("FAIL rstmid_decode: got %0d want %0d", phase_code(), C_D); end
    $display("reset mid-instruction done");
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_free_run(3, "free_run");
    test_stall_execute();
    test_stall_other();
    test_halt();
    test_step_resume();
    test_free_run(8, "wrap");
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
